// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : NUM_REGS x DATA_W register file. It has two combinational read
//            ports, one write port with same-cycle write-to-read bypass, and
//            a per-register busy scoreboard used for RAW hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  output logic              rd1_busy,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  output logic              rd2_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              any_busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_any_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam bit c_HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
      logic w_set;
      logic w_clr;

      assign w_set = iss_en && (iss_addr == ADDR_W'(gi));
      assign w_clr = we && (wa == ADDR_W'(gi));
      // A new producer issued in the same cycle as a writeback keeps the register pending.
      assign w_busy_next[gi] = c_HARD_ZERO ? 1'b0 :
                               w_set       ? 1'b1 :
                               w_clr       ? 1'b0 : r_busy[gi];

      always_ff @(posedge clk) begin
        if (rst || c_HARD_ZERO) begin
          r_regs[gi] <= '0;
        end else if (w_clr) begin
          r_regs[gi] <= wd;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_any_busy <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_any_busy <= |w_busy_next;
    end
  end

  assign any_busy = r_any_busy;

  logic w_zero1;
  logic w_zero2;
  logic w_hit1;
  logic w_hit2;

  assign w_zero1 = (ZERO_REG != 0) && (ra1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (ra2 == '0);
  assign w_hit1  = we && (wa == ra1) && !w_zero1;
  assign w_hit2  = we && (wa == ra2) && !w_zero2;

  // Bypassed data is valid this cycle, so a hit port never reports busy.
  always_comb begin
    rd1      = '0;
    rd2      = '0;
    rd1_busy = 1'b0;
    rd2_busy = 1'b0;
    if (!rst) begin
      rd1      = w_hit1 ? wd : (w_zero1 ? '0 : r_regs[ra1]);
      rd2      = w_hit2 ? wd : (w_zero2 ? '0 : r_regs[ra2]);
      rd1_busy = r_busy[ra1] && !w_hit1;
      rd2_busy = r_busy[ra2] && !w_hit2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// Testbench for reg_file_sb: directed vectors drive two instances (32x32 with
// hard-wired r0, and 8x16 ordinary); a monitor pops expected values and compares.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  // instance A: DATA_W=32, ADDR_W=5, ZERO_REG=1
  logic [4:0]  a_ra1, a_ra2, a_wa, a_iss_addr;
  logic [31:0] a_wd, a_rd1, a_rd2;
  logic        a_we, a_iss_en, a_rd1_busy, a_rd2_busy, a_any_busy;
  // instance B: DATA_W=16, ADDR_W=3, ZERO_REG=0
  logic [2:0]  b_ra1, b_ra2, b_wa, b_iss_addr;
  logic [15:0] b_wd, b_rd1, b_rd2;
  logic        b_we, b_iss_en, b_rd1_busy, b_rd2_busy, b_any_busy;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst),
    .ra1(a_ra1), .rd1(a_rd1), .rd1_busy(a_rd1_busy),
    .ra2(a_ra2), .rd2(a_rd2), .rd2_busy(a_rd2_busy),
    .we(a_we), .wa(a_wa), .wd(a_wd),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .any_busy(a_any_busy)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst),
    .ra1(b_ra1), .rd1(b_rd1), .rd1_busy(b_rd1_busy),
    .ra2(b_ra2), .rd2(b_rd2), .rd2_busy(b_rd2_busy),
    .we(b_we), .wa(b_wa), .wd(b_wd),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .any_busy(b_any_busy)
  );

  localparam int S_RD1 = 0, S_RD2 = 1, S_RD1B = 2, S_RD2B = 3, S_ANYB = 4;

  typedef struct {
    int          inst;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  function automatic logic [31:0] observe(int inst, int sig);
    logic [31:0] v;
    v = '0;
    if (inst == 0) begin
      case (sig)
        S_RD1:   v = a_rd1;
        S_RD2:   v = a_rd2;
        S_RD1B:  v = {31'b0, a_rd1_busy};
        S_RD2B:  v = {31'b0, a_rd2_busy};
        default: v = {31'b0, a_any_busy};
      endcase
    end else begin
      case (sig)
        S_RD1:   v = {16'b0, b_rd1};
        S_RD2:   v = {16'b0, b_rd2};
        S_RD1B:  v = {31'b0, b_rd1_busy};
        S_RD2B:  v = {31'b0, b_rd2_busy};
        default: v = {31'b0, b_any_busy};
      endcase
    end
    return v;
  endfunction

  // Monitor: compares every queued expectation away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = observe(e.inst, e.sig);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(int inst, int sig, logic [31:0] v, string name);
    exp_t e;
    e.inst = inst; e.sig = sig; e.exp = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we = 0; a_wa = '0; a_wd = '0; a_iss_en = 0; a_iss_addr = '0;
    b_we = 0; b_wa = '0; b_wd = '0; b_iss_en = 0; b_iss_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    a_ra1 = '0; a_ra2 = '0; b_ra1 = '0; b_ra2 = '0;
    tick();
    tick();
    expect_v(0, S_ANYB, 0, "reset_anyb");
    expect_v(1, S_ANYB, 0, "reset_b_anyb");

    // T1: preload r5 and mark it busy, then reset with a competing write
    tick();
    rst = 1'b0;
    a_we = 1; a_wa = 5; a_wd = 32'hDEAD_BEEF; a_iss_en = 1; a_iss_addr = 5;
    tick();
    idle(); a_ra1 = 5;
    expect_v(0, S_RD1,  32'hDEAD_BEEF, "t1_preload_rd1");
    expect_v(0, S_RD1B, 1, "t1_preload_busy");
    expect_v(0, S_ANYB, 1, "t1_preload_anyb");
    tick();
    rst = 1'b1; a_we = 1; a_wa = 5; a_wd = 32'd1;
    expect_v(0, S_RD1,  0, "t1_rst_forces_rd1");
    expect_v(0, S_RD1B, 0, "t1_rst_forces_busy");
    tick();
    rst = 1'b0; idle();
    expect_v(0, S_RD1,  0, "t1_after_rst_rd1");
    expect_v(0, S_RD1B, 0, "t1_after_rst_busy");
    expect_v(0, S_ANYB, 0, "t1_after_rst_anyb");
    tick();

    // T2: write with same-cycle bypass on both ports
    a_we = 1; a_wa = 7; a_wd = 32'h1234_5678; a_ra1 = 7; a_ra2 = 7;
    expect_v(0, S_RD1, 32'h1234_5678, "t2_bypass_rd1");
    expect_v(0, S_RD2, 32'h1234_5678, "t2_bypass_rd2");
    tick();
    idle();
    expect_v(0, S_RD1, 32'h1234_5678, "t2_stored_rd1");
    expect_v(0, S_RD2, 32'h1234_5678, "t2_stored_rd2");
    tick();

    // T3: r0 ignores writes and issues
    a_we = 1; a_wa = 0; a_wd = 32'hFFFF_FFFF; a_iss_en = 1; a_iss_addr = 0; a_ra1 = 0;
    expect_v(0, S_RD1,  0, "t3_r0_same_rd1");
    expect_v(0, S_RD1B, 0, "t3_r0_same_busy");
    tick();
    idle();
    expect_v(0, S_RD1,  0, "t3_r0_next_rd1");
    expect_v(0, S_RD1B, 0, "t3_r0_next_busy");
    expect_v(0, S_ANYB, 0, "t3_r0_anyb");
    tick();

    // T4: issue r3, hold busy, writeback clears
    a_iss_en = 1; a_iss_addr = 3; a_ra1 = 3; a_ra2 = 7;
    expect_v(0, S_RD1B, 0, "t4_n_busy");
    tick();
    idle();
    expect_v(0, S_RD1B, 1, "t4_n1_busy");
    expect_v(0, S_ANYB, 1, "t4_n1_anyb");
    expect_v(0, S_RD2B, 0, "t4_other_reg_idle");
    tick();
    tick();
    expect_v(0, S_RD1B, 1, "t4_n3_busy");
    tick();
    a_we = 1; a_wa = 3; a_wd = 32'd9;
    expect_v(0, S_RD1,  9, "t4_wb_bypass");
    expect_v(0, S_RD1B, 0, "t4_wb_not_busy");
    expect_v(0, S_ANYB, 1, "t4_wb_anyb_lags");
    tick();
    idle();
    expect_v(0, S_RD1,  9, "t4_after_rd1");
    expect_v(0, S_RD1B, 0, "t4_after_busy");
    expect_v(0, S_ANYB, 0, "t4_after_anyb");
    tick();

    // T5: set wins over simultaneous clear
    a_iss_en = 1; a_iss_addr = 4;
    tick();
    idle();
    a_iss_en = 1; a_iss_addr = 4; a_we = 1; a_wa = 4; a_wd = 32'd11; a_ra1 = 4; a_ra2 = 4;
    expect_v(0, S_RD1,  11, "t5_coll_rd1");
    expect_v(0, S_RD1B, 0, "t5_coll_busy");
    tick();
    idle();
    expect_v(0, S_RD1,  11, "t5_next_rd1");
    expect_v(0, S_RD1B, 1, "t5_next_busy");
    expect_v(0, S_RD2B, 1, "t5_next_busy2");
    expect_v(0, S_ANYB, 1, "t5_next_anyb");
    tick();
    // re-issue while busy, then one writeback clears it
    a_iss_en = 1; a_iss_addr = 4;
    tick();
    idle(); a_we = 1; a_wa = 4; a_wd = 32'd12;
    tick();
    idle();
    expect_v(0, S_RD1,  12, "t5_reissue_rd1");
    expect_v(0, S_RD1B, 0, "t5_reissue_cleared");
    expect_v(0, S_ANYB, 0, "t5_reissue_anyb");
    tick();
    // writeback to a non-busy register is legal and leaves it idle
    a_we = 1; a_wa = 4; a_wd = 32'd13;
    tick();
    idle();
    expect_v(0, S_RD1,  13, "t5_nonbusy_wb");
    expect_v(0, S_RD1B, 0, "t5_nonbusy_busy");
    tick();

    // T6: 8x16, r0 ordinary
    b_we = 1; b_wa = 0; b_wd = 16'hA5A5;
    tick();
    idle(); b_ra1 = 0;
    expect_v(1, S_RD1, 32'h0000_A5A5, "t6_r0_readback");
    tick();
    for (int i = 0; i < 8; i++) begin
      b_we = 1; b_wa = 3'(i); b_wd = 16'h1000 + 16'(i * 16'h0111);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      b_ra1 = 3'(i); b_ra2 = 3'(7 - i);
      expect_v(1, S_RD1, 32'(16'h1000 + 16'(i * 16'h0111)), $sformatf("t6_alias_rd1_r%0d", i));
      expect_v(1, S_RD2, 32'(16'h1000 + 16'((7 - i) * 16'h0111)), $sformatf("t6_alias_rd2_r%0d", 7 - i));
      tick();
    end
    b_iss_en = 1; b_iss_addr = 0; b_ra1 = 0;
    tick();
    idle();
    expect_v(1, S_RD1B, 1, "t6_r0_goes_busy");
    expect_v(1, S_ANYB, 1, "t6_r0_anyb");
    tick();
    tick();

    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    if (!done) begin
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
